// File: rtl/rock_tuner.sv
// rock_tuner: hill-climbing tuner for rocking amplitude/frequency driven by stress-delta flags.
// Revision: 1.0
`default_nettype none

module rock_tuner #(
   parameter int SETTLE_CYCLES = 1000,
   parameter int CW            = 16,
   parameter int STABLE_LIMIT  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] status,
   input  logic       gedaald,
   input  logic       gelijk,
   output logic [1:0] amplitude,
   output logic [1:0] frequency,
   output logic       param_sel,
   output logic       busy,
   output logic       calm
);

   localparam int SW = (STABLE_LIMIT < 1) ? 1 : $clog2(STABLE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      EVAL   = 2'd2,
      CALM   = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] settle_cnt;
   logic [SW-1:0] stable_cnt;
   logic          dir_down;
   logic          last_valid;
   logic          last_param;
   logic          last_down;

   // One saturating step within the active range 1..3.
   function automatic logic [1:0] step_val(input logic [1:0] v, input logic down);
      logic [1:0] r;
      r = v;
      if (down) begin
         if (v > 2'd1) r = v - 2'd1;
      end else begin
         if (v < 2'd3) r = v + 2'd1;
      end
      return r;
   endfunction

   logic [1:0]    sel_val, sel_step, oth_val, oth_step, undo_val, undo_step;
   logic          sel_moved, oth_moved, stable_hit;
   logic [SW-1:0] stable_next;

   assign sel_val     = param_sel ? frequency : amplitude;
   assign sel_step    = step_val(sel_val, dir_down);
   assign sel_moved   = (sel_step != sel_val);
   assign oth_val     = param_sel ? amplitude : frequency;
   assign oth_step    = step_val(oth_val, dir_down);
   assign oth_moved   = (oth_step != oth_val);
   assign undo_val    = last_param ? frequency : amplitude;
   assign undo_step   = step_val(undo_val, ~last_down);
   assign stable_next = stable_cnt + 1'b1;
   assign stable_hit  = (stable_next == SW'(STABLE_LIMIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         amplitude  <= 2'd0;
         frequency  <= 2'd0;
         param_sel  <= 1'b0;
         busy       <= 1'b0;
         calm       <= 1'b0;
         settle_cnt <= '0;
         stable_cnt <= '0;
         dir_down   <= 1'b0;
         last_valid <= 1'b0;
         last_param <= 1'b0;
         last_down  <= 1'b0;
      end else if (!enable) begin
         state      <= IDLE;
         amplitude  <= 2'd0;
         frequency  <= 2'd0;
         param_sel  <= 1'b0;
         busy       <= 1'b0;
         calm       <= 1'b0;
         settle_cnt <= '0;
         stable_cnt <= '0;
         dir_down   <= 1'b0;
         last_valid <= 1'b0;
         last_param <= 1'b0;
         last_down  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (status != 3'd0) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  amplitude  <= 2'd1;
                  frequency  <= 2'd1;
                  param_sel  <= 1'b0;
                  dir_down   <= 1'b0;
                  last_valid <= 1'b0;
               end
            end

            SETTLE: begin
               if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= '0;
                  state      <= EVAL;
                  busy       <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            EVAL: begin
               if (status == 3'd0) begin
                  state      <= CALM;
                  calm       <= 1'b1;
                  stable_cnt <= '0;
               end else begin
                  state <= SETTLE;
                  busy  <= 1'b1;
                  if (gedaald) begin
                     stable_cnt <= '0;
                     if (sel_moved) begin
                        if (param_sel) frequency <= sel_step;
                        else           amplitude <= sel_step;
                        last_valid <= 1'b1;
                        last_param <= param_sel;
                        last_down  <= dir_down;
                     end else begin
                        // Saturated: give the other parameter a turn.
                        last_valid <= 1'b0;
                        param_sel  <= ~param_sel;
                     end
                  end else if (gelijk) begin
                     if (stable_hit) begin
                        stable_cnt <= '0;
                        param_sel  <= ~param_sel;
                        if (param_sel) amplitude <= oth_step;
                        else           frequency <= oth_step;
                        last_valid <= oth_moved;
                        last_param <= ~param_sel;
                        last_down  <= dir_down;
                     end else begin
                        stable_cnt <= stable_next;
                     end
                  end else begin
                     // Stress rose: take back the last move and head the other way.
                     if (last_valid) begin
                        if (last_param) frequency <= undo_step;
                        else            amplitude <= undo_step;
                     end
                     last_valid <= 1'b0;
                     dir_down   <= ~dir_down;
                     stable_cnt <= '0;
                  end
               end
            end

            CALM: begin
               if (status != 3'd0) begin
                  state      <= SETTLE;
                  calm       <= 1'b0;
                  busy       <= 1'b1;
                  last_valid <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
